// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB stage: writeback mux selects, load
// funct3 codes and the stage occupancy state.
package wb_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } stage_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load alignment: picks the addressed byte/half out of a dmem word,
// sign- or zero-extends it, and flags sub-word misalignment.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [XLEN-1:0] s;
    s = $signed({sgn & b[7], b});
    return s;
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [XLEN-1:0] s;
    s = $signed({sgn & h[15], h});
    return s;
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = raw[{off, 3'b000} +: 8];
  assign half_sel = raw[{off[1], 4'b0000} +: 16];

  // Extend the selected lane; unknown load types pass the word through.
  always_comb begin
    data     = raw;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = ext8(byte_sel, 1'b1);
      F3_LBU: data = ext8(byte_sel, 1'b0);
      F3_LH:  begin data = ext16(half_sel, 1'b1); misalign = off[0]; end
      F3_LHU: begin data = ext16(half_sel, 1'b0); misalign = off[0]; end
      F3_LW:  misalign = |off;
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers EX/MEM results, aligns synchronous dmem
// read data, and keeps that data in a hold register across writeback stalls.
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_alu,
  input  logic [XLEN-1:0]       in_pc4,
  input  logic [XLEN-1:0]       in_csr,
  input  logic [1:0]            in_wb_sel,
  input  logic [2:0]            in_funct3,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_we,
  input  logic [XLEN-1:0]       dmem_rdata,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [XLEN-1:0]       wb_in0,
  output logic [XLEN-1:0]       wb_in1,
  output logic [XLEN-1:0]       wb_in2,
  output logic [XLEN-1:0]       wb_in3,
  output logic [1:0]            wb_sel,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_we,
  output logic                  wb_misalign
);

  stage_t                state_p1, state_d;
  logic [XLEN-1:0]       alu_p1, pc4_p1, csr_p1, hold_p1;
  logic [1:0]            sel_p1;
  logic [2:0]            f3_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic                  we_p1;
  logic                  vld_p1;
  logic                  accept;
  logic [XLEN-1:0]       raw;
  logic                  align_mis;

  assign vld_p1    = (state_p1 != EMPTY);
  assign out_valid = vld_p1;
  assign in_ready  = !vld_p1 | out_ready;
  assign accept    = in_valid & in_ready;

  // Next occupancy: flush wins, then a new accept, then drain or stall.
  always_comb begin
    state_d = state_p1;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FRESH;
    end else begin
      case (state_p1)
        FRESH:   state_d = out_ready ? EMPTY : HELD;
        HELD:    state_d = out_ready ? EMPTY : HELD;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Stage occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p1 <= EMPTY;
    else        state_p1 <= state_d;
  end

  // EX/MEM -> MEM/WB boundary: capture instruction fields on a surviving accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_p1 <= '0;
      pc4_p1 <= '0;
      csr_p1 <= '0;
      sel_p1 <= WB_ALU;
      f3_p1  <= F3_LB;
      rd_p1  <= '0;
      we_p1  <= 1'b0;
    end else if (accept && !flush) begin
      alu_p1 <= in_alu;
      pc4_p1 <= in_pc4;
      csr_p1 <= in_csr;
      sel_p1 <= in_wb_sel;
      f3_p1  <= in_funct3;
      rd_p1  <= in_rd;
      we_p1  <= in_reg_we;
    end
  end

  // dmem data is only present for one cycle; keep it when the first live cycle stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                hold_p1 <= '0;
    else if (state_p1 == FRESH && !out_ready)  hold_p1 <= dmem_rdata;
  end

  assign raw = (state_p1 == FRESH) ? dmem_rdata : hold_p1;

  load_align #(.XLEN(XLEN)) u_align (
    .raw      (raw),
    .off      (alu_p1[1:0]),
    .funct3   (f3_p1),
    .data     (wb_in1),
    .misalign (align_mis)
  );

  assign wb_in0      = alu_p1;
  assign wb_in2      = pc4_p1;
  assign wb_in3      = csr_p1;
  assign wb_sel      = sel_p1;
  assign wb_rd       = rd_p1;
  assign wb_we       = we_p1 & vld_p1;
  assign wb_misalign = vld_p1 & (sel_p1 == WB_MEM) & align_mis;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a randomized
// run against an instruction-level reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_alu = '0, in_pc4 = '0, in_csr = '0;
  logic [1:0]  in_wb_sel = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_we = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [31:0] wb_in0, wb_in1, wb_in2, wb_in3;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;
  logic        wb_we, wb_misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_pc4(in_pc4), .in_csr(in_csr), .in_wb_sel(in_wb_sel),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_reg_we(in_reg_we),
    .dmem_rdata(dmem_rdata), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .wb_in0(wb_in0), .wb_in1(wb_in1), .wb_in2(wb_in2),
    .wb_in3(wb_in3), .wb_sel(wb_sel), .wb_rd(wb_rd), .wb_we(wb_we),
    .wb_misalign(wb_misalign)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] csr,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd, input logic we);
    in_valid = 1'b1; in_alu = alu; in_pc4 = pc4; in_csr = csr;
    in_wb_sel = sel; in_funct3 = f3; in_rd = rd; in_reg_we = we;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  // Reference load result from arithmetic on the addressed lane.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] word, input logic [31:0] addr);
    int unsigned off, b, h;
    off = addr % 4;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> ((off / 2) * 16)) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd5: return h;
      default: return word;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    if (sel != 2'd1) return 1'b0;
    if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 == 1)) return 1'b1;
    if (f3 == 3'd2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we got=%0h exp=0", wb_we); end
    checks++; if ({wb_in0, wb_in1, wb_in2, wb_in3} !== 128'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", {wb_in0, wb_in1, wb_in2, wb_in3}); end
    checks++; if ({wb_sel, wb_rd, wb_misalign} !== 8'd0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", {wb_sel, wb_rd, wb_misalign}); end
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_lw();
    out_ready = 1'b1;
    drive(32'h100, 32'h104, 32'h0, 2'd1, 3'd2, 5'd5, 1'b1);
    cyc();
    idle(); dmem_rdata = 32'hDEADBEEF; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lw_out_valid got=%0h exp=1", out_valid); end
    checks++; if (wb_in1 !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_wb_in1 got=%h exp=deadbeef", wb_in1); end
    checks++; if (wb_sel !== 2'd1) begin errors++; $display("FAIL lw_wb_sel got=%0d exp=1", wb_sel); end
    checks++; if (wb_misalign !== 1'b0) begin errors++; $display("FAIL lw_misalign got=%0h exp=0", wb_misalign); end
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd5) begin errors++; $display("FAIL lw_we_rd got=%0h/%0d exp=1/5", wb_we, wb_rd); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lw_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_byte_half();
    logic [2:0]  f3s  [3] = '{3'd0, 3'd4, 3'd5};
    logic [31:0] alus [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exps [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(alus[i], 32'h0, 32'h0, 2'd1, f3s[i], 5'd1, 1'b1);
      cyc();
      idle(); dmem_rdata = 32'h80FF7F01; #1;
      checks++; if (wb_in1 !== exps[i]) begin errors++; $display("FAIL byte_half_%0d got=%h exp=%h", i, wb_in1, exps[i]); end
      cyc();
    end
  endtask

  task automatic test_stall_hold();
    out_ready = 1'b1;
    drive(32'h100, 32'h0, 32'h0, 2'd1, 3'd2, 5'd3, 1'b1);
    cyc();
    drive(32'h999, 32'h0, 32'h0, 2'd0, 3'd0, 5'd9, 1'b1);
    out_ready = 1'b0; dmem_rdata = 32'hDEADBEEF; #1;
    checks++; if (wb_in1 !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_first got=%h exp=deadbeef", wb_in1); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready0 got=%0h exp=0", in_ready); end
    for (int k = 0; k < 2; k++) begin
      cyc();
      dmem_rdata = 32'h0; #1;
      checks++; if (wb_in1 !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_hold_%0d got=%h exp=deadbeef", k, wb_in1); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hs_%0d got=%0h/%0h exp=0/1", k, in_ready, out_valid); end
      checks++; if (wb_in0 !== 32'h100 || wb_rd !== 5'd3) begin errors++; $display("FAIL stall_fields_%0d got=%h/%0d exp=100/3", k, wb_in0, wb_rd); end
    end
    cyc();
    idle(); out_ready = 1'b1; #1;
    checks++; if (wb_in1 !== 32'hDEADBEEF || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%h/%0h exp=deadbeef/1", wb_in1, in_ready); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(32'd5, 32'h8, 32'h0, 2'd0, 3'd2, 5'd1, 1'b1);
    cyc();
    drive(32'h77, 32'h24, 32'h0, 2'd2, 3'd2, 5'd2, 1'b1); #1;
    checks++; if (out_valid !== 1'b1 || wb_sel !== 2'd0 || wb_in0 !== 32'd5) begin errors++; $display("FAIL b2b_first got=%0h/%0d/%h exp=1/0/5", out_valid, wb_sel, wb_in0); end
    cyc();
    idle(); #1;
    checks++; if (out_valid !== 1'b1 || wb_sel !== 2'd2 || wb_in2 !== 32'h24) begin errors++; $display("FAIL b2b_second got=%0h/%0d/%h exp=1/2/24", out_valid, wb_sel, wb_in2); end
    checks++; if (wb_rd !== 5'd2) begin errors++; $display("FAIL b2b_rd got=%0d exp=2", wb_rd); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_flush_held();
    out_ready = 1'b1;
    drive(32'h200, 32'h0, 32'h0, 2'd1, 3'd2, 5'd4, 1'b1);
    cyc();
    idle(); out_ready = 1'b0; dmem_rdata = 32'h12345678;
    cyc();
    flush = 1'b1; out_ready = 1'b1;
    drive(32'd9, 32'h0, 32'h0, 2'd0, 3'd2, 5'd7, 1'b1); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0h exp=1", in_ready); end
    cyc();
    idle(); #1;
    checks++; if (out_valid !== 1'b0 || wb_we !== 1'b0) begin errors++; $display("FAIL flush_kill got=%0h/%0h exp=0/0", out_valid, wb_we); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%0h exp=0", out_valid); end
  endtask

  task automatic test_misalign();
    logic [2:0]  f3s  [6] = '{3'd1, 3'd5, 3'd2, 3'd1, 3'd4, 3'd1};
    logic [31:0] alus [6] = '{32'h101, 32'h103, 32'h102, 32'h102, 32'h103, 32'h101};
    logic [1:0]  sels [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    logic        exps [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(alus[i], 32'h0, 32'h0, sels[i], f3s[i], 5'd6, 1'b1);
      cyc();
      idle(); dmem_rdata = $urandom; #1;
      checks++; if (wb_misalign !== exps[i]) begin errors++; $display("FAIL misalign_%0d got=%0h exp=%0h", i, wb_misalign, exps[i]); end
      cyc();
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive(32'h300, 32'h0, 32'h0, 2'd1, 3'd2, 5'd8, 1'b1);
    cyc();
    idle(); out_ready = 1'b0; dmem_rdata = 32'hCAFEF00D;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || wb_we !== 1'b0) begin errors++; $display("FAIL async_rst got=%0h/%0h exp=0/0", out_valid, wb_we); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready got=%0h exp=1", in_ready); end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (wb_in1 !== 32'h0 || wb_in0 !== 32'h0) begin errors++; $display("FAIL async_rst_data got=%h/%h exp=0/0", wb_in1, wb_in0); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_after got=%0h exp=0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_random();
    logic live, first, acc, exp_ready;
    logic [31:0] r_alu, r_pc4, r_csr, r_word, w;
    logic [1:0] r_sel;
    logic [2:0] r_f3;
    logic [4:0] r_rd;
    logic r_we;
    live = 1'b0; first = 1'b0;
    r_alu = '0; r_pc4 = '0; r_csr = '0; r_word = '0; r_sel = '0; r_f3 = '0; r_rd = '0; r_we = 1'b0;
    for (int n = 0; n < 400; n++) begin
      in_valid   = ($urandom % 4) != 0;
      in_alu     = $urandom;
      in_pc4     = $urandom;
      in_csr     = $urandom;
      in_wb_sel  = 2'($urandom % 4);
      in_funct3  = 3'($urandom % 8);
      in_rd      = 5'($urandom % 32);
      in_reg_we  = ($urandom % 2) != 0;
      dmem_rdata = $urandom;
      flush      = ($urandom % 16) == 0;
      out_ready  = ($urandom % 3) != 0;
      #1;
      exp_ready = !live || out_ready;
      checks++; if (out_valid !== live) begin errors++; $display("FAIL rnd_valid n=%0d got=%0h exp=%0h", n, out_valid, live); end
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready n=%0d got=%0h exp=%0h", n, in_ready, exp_ready); end
      checks++; if (wb_we !== (live & r_we)) begin errors++; $display("FAIL rnd_we n=%0d got=%0h exp=%0h", n, wb_we, live & r_we); end
      if (live) begin
        w = first ? dmem_rdata : r_word;
        checks++; if (wb_in1 !== ref_load(r_f3, w, r_alu)) begin errors++; $display("FAIL rnd_load n=%0d got=%h exp=%h", n, wb_in1, ref_load(r_f3, w, r_alu)); end
        checks++; if ({wb_in0, wb_in2, wb_in3} !== {r_alu, r_pc4, r_csr}) begin errors++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, {wb_in0, wb_in2, wb_in3}, {r_alu, r_pc4, r_csr}); end
        checks++; if ({wb_sel, wb_rd} !== {r_sel, r_rd}) begin errors++; $display("FAIL rnd_ctrl n=%0d got=%h exp=%h", n, {wb_sel, wb_rd}, {r_sel, r_rd}); end
        checks++; if (wb_misalign !== ref_mis(r_sel, r_f3, r_alu)) begin errors++; $display("FAIL rnd_mis n=%0d got=%0h exp=%0h", n, wb_misalign, ref_mis(r_sel, r_f3, r_alu)); end
      end
      acc = in_valid && exp_ready;
      if (flush) begin
        live = 1'b0;
      end else if (acc) begin
        live = 1'b1; first = 1'b1;
        r_alu = in_alu; r_pc4 = in_pc4; r_csr = in_csr; r_sel = in_wb_sel;
        r_f3 = in_funct3; r_rd = in_rd; r_we = in_reg_we;
      end else if (live && out_ready) begin
        live = 1'b0;
      end else if (live && first) begin
        r_word = dmem_rdata; first = 1'b0;
      end
      cyc();
    end
    idle(); out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_half();
    test_stall_hold();
    test_back_to_back();
    test_flush_held();
    test_misalign();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
